// File: rtl/sram_arb2_if.sv
// sram_arb2_if: requester-side bus of the two-port SRAM arbiter
// Signals: req/we/lock/addr/wbe/wdata from the requester; gnt/rvalid/rdata back to it.
// Modports: master (requester), slave (arbiter).
interface sram_arb2_if #(
    parameter int abit = 10,
    parameter int dw   = 32
);
    logic            req;
    logic            we;
    logic            lock;
    logic [abit-1:0] addr;
    logic [3:0]      wbe;
    logic [dw-1:0]   wdata;
    logic            gnt;
    logic            rvalid;
    logic [dw-1:0]   rdata;
    modport master (output req, we, lock, addr, wbe, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wbe, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_arb2.sv
// sram_arb2: two-port single-SRAM arbiter, round-robin ties, bounded burst locking
// Ports: clk, rst (synchronous, active high); p0/p1 requester buses (sram_arb2_if.slave);
//        mem_en/mem_we/mem_wbe/mem_addr/mem_din drive the SRAM, mem_dout is its read data
//        (valid one cycle after a read access).
// Option: define SRAM_ARB_FIXED_PRIO_EN to make port 0 win every tie (prio held at 0).
module sram_arb2 #(
    parameter int mem_abit = 10,
    parameter int mem_dw   = 32,
    parameter int max_lock = 16
) (
    input  logic                clk,
    input  logic                rst,
    sram_arb2_if.slave          p0,
    sram_arb2_if.slave          p1,
    output logic                mem_en,
    output logic                mem_we,
    output logic [3:0]          mem_wbe,
    output logic [mem_abit-1:0] mem_addr,
    output logic [mem_dw-1:0]   mem_din,
    input  logic [mem_dw-1:0]   mem_dout
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN0  = 2'd1;
    localparam logic [1:0] ST_OWN1  = 2'd2;
    localparam logic [7:0] LOCK_MAX = 8'(max_lock);

    logic [1:0]        st_q, st_d;
    logic              prio_q, prio_d;
    logic              fav_v_q, fav_v_d, fav_q, fav_d;
    logic [7:0]        cnt_q, cnt_d, cnt_nx;
    logic [1:0]        rv_q, rv_d;
    logic [mem_dw-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              tie, g0, g1, gnt, lk, expire, rv0, rv1;

    always_comb begin
        // a lock that just expired hands the next tie to the waiting port
        tie     = fav_v_q ? fav_q : prio_q;
        g0      = !rst && p0.req && (st_q == ST_OWN0 || (st_q == ST_IDLE && !(p1.req && tie)));
        g1      = !rst && p1.req && (st_q == ST_OWN1 || (st_q == ST_IDLE && !(p0.req && !tie)));
        gnt     = g0 || g1;
        lk      = g1 ? p1.lock : p0.lock;
        cnt_nx  = st_q == ST_IDLE ? 8'd1 : (cnt_q == 8'hff ? cnt_q : cnt_q + 8'd1);
        expire  = gnt && lk && cnt_nx >= LOCK_MAX;
        // no grant while owned means the owner dropped req: release
        st_d    = gnt && lk && !expire ? (g1 ? ST_OWN1 : ST_OWN0) : ST_IDLE;
        cnt_d   = st_d == ST_IDLE ? 8'd0 : cnt_nx;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        prio_d  = 1'b0;
`else
        prio_d  = gnt ? !g1 : prio_q;
`endif
        fav_v_d = expire;
        fav_d   = !g1;
        rv_d    = {g1 && !p1.we, g0 && !p0.we};
        // masking with rst drops a read issued just before reset
        rv0     = rv_q[0] && !rst;
        rv1     = rv_q[1] && !rst;
        rd0_d   = rst ? '0 : (rv0 ? mem_dout : rd0_q);
        rd1_d   = rst ? '0 : (rv1 ? mem_dout : rd1_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            prio_q  <= 1'b0;
            fav_v_q <= 1'b0;
            fav_q   <= 1'b0;
            cnt_q   <= 8'd0;
            rv_q    <= 2'b00;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            st_q    <= st_d;
            prio_q  <= prio_d;
            fav_v_q <= fav_v_d;
            fav_q   <= fav_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign p0.gnt    = g0;
    assign p1.gnt    = g1;
    assign p0.rvalid = rv0;
    assign p1.rvalid = rv1;
    assign p0.rdata  = rd0_d;
    assign p1.rdata  = rd1_d;
    assign mem_en    = gnt;
    assign mem_we    = (g0 && p0.we) || (g1 && p1.we);
    assign mem_wbe   = g0 ? p0.wbe : (g1 ? p1.wbe : 4'd0);
    assign mem_addr  = g1 ? p1.addr : p0.addr;
    assign mem_din   = g1 ? p1.wdata : p0.wdata;
endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: self-checking bench for sram_arb2 (vector table, directed bursts, random vs reference model)
module tb_sram_arb2;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam int MAXL = 16;

    typedef struct {
        bit          rs, r0, r1, w0, w1;
        logic [9:0]  a0, a1;
        bit          eg0, eg1, ev0, ev1;
        logic [31:0] erd0, erd1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wbe;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    sram_arb2_if #(.abit(10), .dw(32)) i0 ();
    sram_arb2_if #(.abit(10), .dw(32)) i1 ();

    sram_arb2 #(.mem_abit(10), .mem_dw(32), .max_lock(MAXL)) dut (
        .clk(clk), .rst(rst), .p0(i0), .p1(i1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wbe(mem_wbe),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] sram [1024];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wbe[b]) sram[mem_addr][8*b +: 8] = mem_din[8*b +: 8];
        end else if (mem_en) begin
            mem_dout <= sram[mem_addr];
        end
    end

    // reference model: current owner (-1 none), beats in burst, tie pointer, favoured port after expiry
    logic [31:0] ref_mem [1024];
    int          own = -1, beats = 0, rr = 0, fav = -1;
    bit          pend [2];
    logic [31:0] pdat [2];
    logic [31:0] held [2];
    int          n_chk = 0, n_pass = 0;
    bit          og0, og1, ov0, ov1, oen;
    logic [31:0] od0;
    vec_t        tbl [11];
    bit          hg0 [32];
    bit          hg1 [32];
    int          run;
    bit          sticky;

    function automatic logic [31:0] pre(int i);
        return (i == 5) ? 32'h0 : (32'hC0DE0000 | 32'(i));
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic drv(int p, bit r, bit w, bit l, logic [9:0] a, logic [3:0] b, logic [31:0] d);
        if (p == 0) begin
            i0.req = r; i0.we = w; i0.lock = l; i0.addr = a; i0.wbe = b; i0.wdata = d;
        end else begin
            i1.req = r; i1.we = w; i1.lock = l; i1.addr = a; i1.wbe = b; i1.wdata = d;
        end
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    endtask

    task automatic cycle();
        bit          r [2], we [2], lk [2], erv [2], act_v [2];
        logic [9:0]  a [2];
        logic [3:0]  be [2];
        logic [31:0] d [2], erd [2], act_d [2];
        int          w;
        @(negedge clk);
        r = '{i0.req, i1.req}; we = '{i0.we, i1.we}; lk = '{i0.lock, i1.lock};
        a = '{i0.addr, i1.addr}; be = '{i0.wbe, i1.wbe}; d = '{i0.wdata, i1.wdata};
        act_v = '{i0.rvalid, i1.rvalid}; act_d = '{i0.rdata, i1.rdata};
        w = -1;
        if (!rst) begin
            if (own >= 0) w = r[own] ? own : -1;
            else if (r[0] && r[1]) w = (fav >= 0) ? fav : rr;
            else if (r[0]) w = 0;
            else if (r[1]) w = 1;
        end
        check("gnt0", i0.gnt, w == 0);
        check("gnt1", i1.gnt, w == 1);
        check("mem_en", mem_en, w >= 0);
        check("mem_we", mem_we, w >= 0 && we[w]);
        check("mem_wbe", mem_wbe, w >= 0 ? be[w] : 4'h0);
        if (w >= 0) begin
            check("mem_addr", mem_addr, a[w]);
            check("mem_din", mem_din, d[w]);
        end
        for (int n = 0; n < 2; n++) begin
            erv[n] = !rst && pend[n];
            erd[n] = rst ? 32'h0 : (erv[n] ? pdat[n] : held[n]);
            check($sformatf("rvalid%0d", n), act_v[n], erv[n]);
            check($sformatf("rdata%0d", n), act_d[n], erd[n]);
            held[n] = erd[n];
        end
        og0 = i0.gnt; og1 = i1.gnt; ov0 = i0.rvalid; ov1 = i1.rvalid; oen = mem_en; od0 = i0.rdata;
        pend = '{1'b0, 1'b0};
        if (rst) begin
            own = -1; beats = 0; rr = 0; fav = -1;
        end else begin
            fav = -1;
            if (w >= 0) begin
                if (we[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[a[w]][8*b +: 8] = d[w][8*b +: 8];
                end else begin
                    pend[w] = 1'b1;
                    pdat[w] = ref_mem[a[w]];
                end
                rr = FIXED ? 0 : 1 - w;
                beats = (own < 0) ? 1 : (beats < 255 ? beats + 1 : 255);
                if (lk[w] && beats < MAXL) own = w;
                else begin
                    if (lk[w]) fav = 1 - w;
                    own = -1;
                end
            end else own = -1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i] = pre(i);
            ref_mem[i] = pre(i);
        end
        held = '{32'h0, 32'h0};
        pdat = '{32'h0, 32'h0};
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // both read every cycle -> alternating grants, then write/read-back through byte enables
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE0010, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hC0DE0020};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE0010, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hC0DE0020};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 10'h005, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h005, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000A5A5, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        if (FIXED) begin
            tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE0010, 32'h0};
            tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE0010, 32'h0};
            tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h010, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE0010, 32'h0};
            tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0DE0010, 32'h0};
        end
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rs;
            drv(0, tbl[i].r0, tbl[i].w0, 1'b0, tbl[i].a0, 4'b0011, 32'hA5A5A5A5);
            drv(1, tbl[i].r1, tbl[i].w1, 1'b0, tbl[i].a1, 4'b0011, 32'hA5A5A5A5);
            cycle();
            check($sformatf("tbl%0d_gnt", i), {og0, og1}, {tbl[i].eg0, tbl[i].eg1});
            check($sformatf("tbl%0d_rvalid", i), {ov0, ov1}, {tbl[i].ev0, tbl[i].ev1});
            if (tbl[i].ev0) check($sformatf("tbl%0d_rdata0", i), od0, tbl[i].erd0);
            if (tbl[i].ev1) check($sformatf("tbl%0d_rdata1", i), i1.rdata, tbl[i].erd1);
        end
        check("rdata0_hold", od0, 32'h0000A5A5);

        // lock held for 20 beats against a waiting port 1
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drv(0, 1'b1, 1'b0, 1'b1, 10'(k), 4'h0, 32'h0);
            drv(1, 1'b1, 1'b0, 1'b0, 10'h020, 4'h0, 32'h0);
            cycle();
            hg0[k] = og0; hg1[k] = og1;
        end
        run = 0;
        while (run < 20 && hg0[run]) run++;
        check("lock_run", 64'(run), 64'd16);
        check("expiry_gnt1", hg1[16], 1'b1);

        // owner drops req after 3 locked beats
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drv(0, k < 3, 1'b0, 1'b1, 10'h001, 4'h0, 32'h0);
            drv(1, 1'b1, 1'b0, 1'b0, 10'h002, 4'h0, 32'h0);
            cycle();
            hg0[k] = og0; hg1[k] = og1;
        end
        check("burst_beats", {hg0[0], hg0[1], hg0[2]}, 3'b111);
        check("drop_gap", {hg0[3], hg1[3]}, 2'b00);
        check("drop_next_gnt1", hg1[4], 1'b1);

        // reset right after a read grant
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
        drv(0, 1'b1, 1'b0, 1'b0, 10'h003, 4'h0, 32'h0);
        cycle();
        check("pre_rst_gnt0", og0, 1'b1);
        rst = 1'b1;
        drv(1, 1'b1, 1'b1, 1'b0, 10'h004, 4'hf, 32'h12345678);
        cycle();
        check("rst_rvalid0", ov0, 1'b0);
        check("rst_gnt", {og0, og1}, 2'b00);
        check("rst_mem_en", oen, 1'b0);
        rst = 1'b0; idle(); cycle();
        check("post_rst_rvalid0", ov0, 1'b0);

        // lock falls exactly on the beat that reaches max_lock
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
        for (int k = 0; k < 18; k++) begin
            drv(0, 1'b1, 1'b0, k < 15, 10'(k), 4'h0, 32'h0);
            drv(1, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
            cycle();
            hg0[k] = og0; hg1[k] = og1;
        end
        run = 0;
        while (run < 18 && hg0[run]) run++;
        check("lockfall_run", 64'(run), 64'd18);

        // continuous tie with no lock
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drv(0, 1'b1, 1'b0, 1'b0, 10'h010, 4'h0, 32'h0);
            drv(1, 1'b1, 1'b0, 1'b0, 10'h020, 4'h0, 32'h0);
            cycle();
            check($sformatf("tie%0d_gnt0", k), og0, FIXED || (k % 2 == 0));
            check($sformatf("tie%0d_gnt1", k), og1, !FIXED && (k % 2 == 1));
        end

        // random traffic against the reference model
        sticky = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) sticky = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++)
                drv(p, sticky ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    sticky ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1)),
                    10'($urandom_range(0, 7)), 4'($urandom), $urandom);
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
